// File: rtl/fpu_sb_pkg.sv
// Shared types and latency table for the dual-lane FPU issue scoreboard.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fpu_sb_pkg;

    typedef enum logic [2:0] {
        FADD  = 3'd0,
        FSUB  = 3'd1,
        FMUL  = 3'd2,
        FDIV  = 3'd3,
        FSQRT = 3'd4,
        FTOI  = 3'd5,
        ITOF  = 3'd6
    } fpu_unit_t;

    localparam logic [4:0] LAT_FADD  = 5'd3;
    localparam logic [4:0] LAT_FSUB  = 5'd3;
    localparam logic [4:0] LAT_FMUL  = 5'd2;
    localparam logic [4:0] LAT_FDIV  = 5'd10;
    localparam logic [4:0] LAT_FSQRT = 5'd8;
    localparam logic [4:0] LAT_FTOI  = 5'd2;
    localparam logic [4:0] LAT_ITOF  = 5'd2;

    // One writeback port reservation.
    typedef struct packed {
        logic       valid;
        logic [4:0] rt;
    } wb_slot_t;

    // Returns 0 for an unknown unit code, which callers treat as illegal.
    function automatic logic [4:0] lat_of(input fpu_unit_t unit);
        case (unit)
            FADD:    lat_of = LAT_FADD;
            FSUB:    lat_of = LAT_FSUB;
            FMUL:    lat_of = LAT_FMUL;
            FDIV:    lat_of = LAT_FDIV;
            FSQRT:   lat_of = LAT_FSQRT;
            FTOI:    lat_of = LAT_FTOI;
            ITOF:    lat_of = LAT_ITOF;
            default: lat_of = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_sb_resv_table.sv
// Writeback reservation table: shifts down one entry per cycle; entry 0 retires.
// Latency: an insert with latency L appears on wb_valid_o L cycles after its grant cycle.
// Backpressure: none internally; the caller must only insert when occupancy < WB_PORTS.
module fpu_sb_resv_table
    import fpu_sb_pkg::*;
#(
    parameter int MAX_LAT  = 16,
    parameter int WB_PORTS = 2,
    parameter int CW       = $clog2(WB_PORTS + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [4:0]            u_lat_i,
    input  logic [4:0]            l_lat_i,
    input  logic                  u_ins_i,
    input  logic [4:0]            u_rt_i,
    input  logic                  l_ins_i,
    input  logic [4:0]            l_rt_i,
    output logic [CW-1:0]         u_occ_o,
    output logic [CW-1:0]         l_occ_o,
    output logic [WB_PORTS-1:0]   wb_valid_o,
    output logic [5*WB_PORTS-1:0] wb_rt_o
);

    localparam int IW = $clog2(MAX_LAT);

    wb_slot_t tbl_q   [MAX_LAT][WB_PORTS];
    wb_slot_t tbl_d   [MAX_LAT][WB_PORTS];
    wb_slot_t shifted [MAX_LAT][WB_PORTS];

    // Window advance: every entry moves one step closer to retirement.
    always_comb begin
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            for (int s = 0; s < WB_PORTS; s++) begin
                shifted[i][s] = tbl_q[i+1][s];
            end
        end
        for (int s = 0; s < WB_PORTS; s++) begin
            shifted[MAX_LAT-1][s] = '0;
        end
    end

    // Place new inserts in the lowest free slot; u is served before l so
    // that a same-entry pair lands u in the lower slot.
    always_comb begin : alloc
        logic u_pend;
        logic l_pend;
        u_pend = 1'b0;
        l_pend = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            u_pend = u_ins_i && (int'(u_lat_i) == i + 1);
            l_pend = l_ins_i && (int'(l_lat_i) == i + 1);
            for (int s = 0; s < WB_PORTS; s++) begin
                tbl_d[i][s] = shifted[i][s];
                if (!shifted[i][s].valid) begin
                    if (u_pend) begin
                        tbl_d[i][s] = {1'b1, u_rt_i};
                        u_pend      = 1'b0;
                    end else if (l_pend) begin
                        tbl_d[i][s] = {1'b1, l_rt_i};
                        l_pend      = 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy of the entry each lane would land in (valid slots only).
    always_comb begin
        u_occ_o = '0;
        l_occ_o = '0;
        for (int s = 0; s < WB_PORTS; s++) begin
            if (int'(u_lat_i) < MAX_LAT && tbl_q[u_lat_i[IW-1:0]][s].valid) begin
                u_occ_o = u_occ_o + CW'(1);
            end
            if (int'(l_lat_i) < MAX_LAT && tbl_q[l_lat_i[IW-1:0]][s].valid) begin
                l_occ_o = l_occ_o + CW'(1);
            end
        end
    end

    // Table state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                for (int s = 0; s < WB_PORTS; s++) begin
                    tbl_q[i][s] <= '0;
                end
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Entry 0 is the set of results writing back this cycle.
    always_comb begin
        for (int s = 0; s < WB_PORTS; s++) begin
            wb_valid_o[s]      = tbl_q[0][s].valid;
            wb_rt_o[5*s +: 5]  = tbl_q[0][s].rt;
        end
    end

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// Dual-lane FPU issue scoreboard: RAW/WAW hazards, writeback port reservation, busy vector.
// Latency: grant/interlock combinational; busy and wb_* registered. Optional FPU_SB_STATS_EN adds stall counters.
// Backpressure: stalled requests hold fetch/decode via interlock; lower lane never issues past a stalled upper lane.
module fpu_issue_scoreboard
    import fpu_sb_pkg::*;
#(
    parameter int MAX_LAT  = 16,
    parameter int WB_PORTS = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_req_valid,
    input  logic [2:0]            u_req_unit,
    input  logic [4:0]            u_req_rt,
    input  logic                  u_req_rt_flag,
    input  logic [4:0]            u_req_rsa,
    input  logic [4:0]            u_req_rsb,
    input  logic                  u_req_rsa_en,
    input  logic                  u_req_rsb_en,
    input  logic                  l_req_valid,
    input  logic [2:0]            l_req_unit,
    input  logic [4:0]            l_req_rt,
    input  logic                  l_req_rt_flag,
    input  logic [4:0]            l_req_rsa,
    input  logic [4:0]            l_req_rsb,
    input  logic                  l_req_rsa_en,
    input  logic                  l_req_rsb_en,
    output logic                  u_grant,
    output logic                  l_grant,
    output logic                  interlock,
    output logic [31:0]           busy,
    output logic [WB_PORTS-1:0]   wb_valid,
    output logic [5*WB_PORTS-1:0] wb_rt
`ifdef FPU_SB_STATS_EN
    ,
    output logic [31:0]           stall_raw,
    output logic [31:0]           stall_waw,
    output logic [31:0]           stall_port,
    output logic [31:0]           issued
`endif
);

    localparam int CW = $clog2(WB_PORTS + 1);

    logic [31:0]   busy_q, busy_d, busy_set, busy_clr;
    logic [4:0]    lat_u, lat_l;
    logic          legal_u, legal_l;
    logic          raw_u, waw_u, port_u;
    logic          raw_l, waw_l, port_l;
    logic          xraw_l, xwaw_l, order_ok;
    logic [CW-1:0] u_occ, l_occ;
    logic [CW:0]   l_cnt;

    assign lat_u   = lat_of(fpu_unit_t'(u_req_unit));
    assign lat_l   = lat_of(fpu_unit_t'(l_req_unit));
    assign legal_u = (lat_u != 5'd0) && (int'(lat_u) < MAX_LAT);
    assign legal_l = (lat_l != 5'd0) && (int'(lat_l) < MAX_LAT);

    fpu_sb_resv_table #(
        .MAX_LAT  (MAX_LAT),
        .WB_PORTS (WB_PORTS),
        .CW       (CW)
    ) u_table (
        .clk        (clk),
        .rstn       (rstn),
        .u_lat_i    (lat_u),
        .l_lat_i    (lat_l),
        .u_ins_i    (u_grant & u_req_rt_flag),
        .u_rt_i     (u_req_rt),
        .l_ins_i    (l_grant & l_req_rt_flag),
        .l_rt_i     (l_req_rt),
        .u_occ_o    (u_occ),
        .l_occ_o    (l_occ),
        .wb_valid_o (wb_valid),
        .wb_rt_o    (wb_rt)
    );

    // Hazard and port checks for both lanes; l is evaluated after u's decision.
    always_comb begin
        raw_u    = (u_req_rsa_en & busy_q[u_req_rsa]) | (u_req_rsb_en & busy_q[u_req_rsb]);
        waw_u    = u_req_rt_flag & busy_q[u_req_rt];
        port_u   = int'(u_occ) >= WB_PORTS;
        u_grant  = u_req_valid & legal_u & ~raw_u & ~waw_u & ~port_u;

        order_ok = u_grant | ~u_req_valid;
        xraw_l   = u_grant & u_req_rt_flag &
                   ((l_req_rsa_en & (l_req_rsa == u_req_rt)) |
                    (l_req_rsb_en & (l_req_rsb == u_req_rt)));
        xwaw_l   = u_grant & u_req_rt_flag & l_req_rt_flag & (l_req_rt == u_req_rt);
        raw_l    = (l_req_rsa_en & busy_q[l_req_rsa]) | (l_req_rsb_en & busy_q[l_req_rsb]) | xraw_l;
        waw_l    = (l_req_rt_flag & busy_q[l_req_rt]) | xwaw_l;
        l_cnt    = {1'b0, l_occ} +
                   (CW+1)'(u_grant & u_req_rt_flag & (lat_l == lat_u));
        port_l   = int'(l_cnt) >= WB_PORTS;
        l_grant  = l_req_valid & legal_l & order_ok & ~raw_l & ~waw_l & ~port_l;

        interlock = (u_req_valid & ~u_grant) | (l_req_valid & ~l_grant);
    end

    // Busy bits: set on a writing grant, cleared when the result retires; set wins.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (u_grant && u_req_rt_flag) busy_set[u_req_rt] = 1'b1;
        if (l_grant && l_req_rt_flag) busy_set[l_req_rt] = 1'b1;
        for (int s = 0; s < WB_PORTS; s++) begin
            if (wb_valid[s]) busy_clr[wb_rt[5*s +: 5]] = 1'b1;
        end
        busy_d = (busy_q & ~busy_clr) | busy_set;
    end

    // Busy register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rstn) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy = busy_q;

    // A register can only retire while busy, and a writer needs it idle, so these never overlap.
    a_no_set_clr: assert property (@(posedge clk) disable iff (!rstn) (busy_set & busy_clr) == 32'd0);

`ifdef FPU_SB_STATS_EN
    logic [31:0] stall_raw_q, stall_waw_q, stall_port_q, issued_q;
    logic        l_cons, raw_ev, waw_ev, port_ev;

    // Per-cycle stall cause, RAW over WAW over port; l only counts when it was eligible to issue.
    always_comb begin
        l_cons  = l_req_valid & legal_l & order_ok;
        raw_ev  = (u_req_valid & legal_u & raw_u) | (l_cons & raw_l);
        waw_ev  = (u_req_valid & legal_u & waw_u) | (l_cons & waw_l);
        port_ev = (u_req_valid & legal_u & port_u) | (l_cons & port_l);
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_raw_q  <= '0;
            stall_waw_q  <= '0;
            stall_port_q <= '0;
            issued_q     <= '0;
        end else begin
            if (raw_ev && stall_raw_q != '1)                         stall_raw_q  <= stall_raw_q + 32'd1;
            else if (!raw_ev && waw_ev && stall_waw_q != '1)         stall_waw_q  <= stall_waw_q + 32'd1;
            else if (!raw_ev && !waw_ev && port_ev && stall_port_q != '1) stall_port_q <= stall_port_q + 32'd1;
            if ((u_grant || l_grant) && issued_q != '1)              issued_q     <= issued_q + 32'd1;
        end
    end

    assign stall_raw  = stall_raw_q;
    assign stall_waw  = stall_waw_q;
    assign stall_port = stall_port_q;
    assign issued     = issued_q;
`endif

endmodule
